// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a valid/ready byte output, framing-error pulse and sticky overrun flag.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling of start, data and stop bits.
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic w_rxs;
    logic w_sample;
    logic w_baud_last;
    logic w_half_last;
    logic w_deliver;
    logic w_accept;
    logic w_handshake;
    logic w_drop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ser_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic r_rxs_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rxs_prev <= 1'b1;
        end else begin
            r_rxs_prev <= w_rxs;
        end
    end

    // r_sync1 already holds the value rxs will take next cycle, so the vote
    // spans rxs at -1/0/+1 without delaying the FSM decision.
    assign w_sample = (r_rxs_prev & w_rxs) | (r_rxs_prev & r_sync1) | (w_rxs & r_sync1);
`else
    assign w_sample = w_rxs;
`endif

    assign w_baud_last = (r_baud_cnt == C_BIT_LAST);
    assign w_half_last = (r_baud_cnt == C_HALF_LAST);
    assign w_deliver   = (r_state == S_STOP) && w_baud_last && w_sample;
    assign w_handshake = r_rx_valid && rx_ready;
    assign w_accept    = w_deliver && (!r_rx_valid || rx_ready);
    assign w_drop      = w_deliver && r_rx_valid && !rx_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_half_last) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= w_sample ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_sample, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop-bit gives half a bit of slack to catch
                    // a start bit that immediately follows.
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (w_sample) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + C_CNT_ONE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (w_handshake) begin
                r_rx_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_handshake) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 50 MHz / 115200 baud.
// Defining UART_RX_MAJORITY_EN also enables the mid-bit glitch rejection scenario.
module tb_uart_rx;

    localparam int CLK_NS = 20;
    localparam int CPB    = 50000000 / 115200;
    localparam int BIT_NS = CPB * CLK_NS;

    logic       clk;
    logic       resetn;
    logic       ser_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int total;
    int bad;
    int hs_cnt;
    int ferr_cyc;
    int ferr_rise;
    logic ferr_prev;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_rx #(
        .CLK_FREQ(50000000),
        .BAUD    (115200)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ser_rx   (ser_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    // Record every completed handshake and every frame_err cycle.
    initial ferr_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            hs_cnt = hs_cnt + 1;
            got_q.push_back(rx_data);
        end
        if (frame_err) ferr_cyc = ferr_cyc + 1;
        if (frame_err && !ferr_prev) ferr_rise = ferr_rise + 1;
        ferr_prev = frame_err;
    end

    initial begin
        #(3ms);
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        ser_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            #(BIT_NS);
        end
        ser_rx = stop_bit;
        #(BIT_NS);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %0h required 00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b required 0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr: got %0b required 0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %0b required 0", overrun); end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int hs0, fe0, n, exp_lat;
        logic [7:0] e, g;
        hs0 = hs_cnt;
        fe0 = ferr_cyc;
        rx_ready = 1'b1;
        exp_lat = CPB * 9 + CPB / 2 + 3;
        exp_q.push_back(8'h55);
        @(negedge clk);
        n = 0;
        fork
            begin
                #3;
                send_frame(8'h55, 1'b1);
            end
            begin
                do begin
                    @(negedge clk);
                    n++;
                end while (!rx_valid && n < 12 * CPB);
            end
        join
        repeat (20) @(negedge clk);
        total++; if (n < exp_lat - 2 || n > exp_lat + 2) begin bad++; $display("[TB] FAIL single_latency: got %0d cycles required %0d +-2", n, exp_lat); end
        total++; if (hs_cnt - hs0 !== 1) begin bad++; $display("[TB] FAIL single_handshakes: got %0d required 1", hs_cnt - hs0); end
        total++; if (ferr_cyc - fe0 !== 0) begin bad++; $display("[TB] FAIL single_ferr: got %0d cycles required 0", ferr_cyc - fe0); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL single_overrun: got %0b required 0", overrun); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL single_data: got nothing required %0h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin bad++; $display("[TB] FAIL single_data: got %0h required %0h", g, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int hs0;
        logic [7:0] e, g;
        hs0 = hs_cnt;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        @(negedge clk);
        #3;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (hs_cnt - hs0 !== 2) begin bad++; $display("[TB] FAIL b2b_handshakes: got %0d required 2", hs_cnt - hs0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL b2b_data: got nothing required %0h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin bad++; $display("[TB] FAIL b2b_data: got %0h required %0h", g, e); end
            end
        end
    endtask

    task automatic test_overrun();
        int hs0;
        logic [7:0] e, g;
        hs0 = hs_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        @(negedge clk);
        #3;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_valid: got %0b required 1", rx_valid); end
        total++; if (rx_data !== 8'h11) begin bad++; $display("[TB] FAIL ovr_data: got %0h required 11", rx_data); end
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag: got %0b required 1", overrun); end
        total++; if (hs_cnt - hs0 !== 0) begin bad++; $display("[TB] FAIL ovr_early_hs: got %0d required 0", hs_cnt - hs0); end
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_valid_clear: got %0b required 0", rx_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_flag_clear: got %0b required 0", overrun); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL ovr_hs_data: got nothing required %0h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin bad++; $display("[TB] FAIL ovr_hs_data: got %0h required %0h", g, e); end
            end
        end
    endtask

    task automatic test_frame_error();
        int hs0, fc0, fr0;
        hs0 = hs_cnt;
        fc0 = ferr_cyc;
        fr0 = ferr_rise;
        rx_ready = 1'b1;
        @(negedge clk);
        #3;
        send_frame(8'h7E, 1'b0);
        #(2 * BIT_NS);
        ser_rx = 1'b1;
        #(BIT_NS);
        repeat (5) @(negedge clk);
        total++; if (ferr_rise - fr0 !== 1) begin bad++; $display("[TB] FAIL ferr_pulses: got %0d required 1", ferr_rise - fr0); end
        total++; if (ferr_cyc - fc0 !== 1) begin bad++; $display("[TB] FAIL ferr_width: got %0d cycles required 1", ferr_cyc - fc0); end
        total++; if (hs_cnt - hs0 !== 0) begin bad++; $display("[TB] FAIL ferr_no_data: got %0d handshakes required 0", hs_cnt - hs0); end
    endtask

    task automatic test_false_start();
        int hs0, fc0;
        hs0 = hs_cnt;
        fc0 = ferr_cyc;
        rx_ready = 1'b1;
        @(negedge clk);
        #3;
        ser_rx = 1'b0;
        #100;
        ser_rx = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        total++; if (hs_cnt - hs0 !== 0) begin bad++; $display("[TB] FAIL glitch_data: got %0d handshakes required 0", hs_cnt - hs0); end
        total++; if (ferr_cyc - fc0 !== 0) begin bad++; $display("[TB] FAIL glitch_ferr: got %0d cycles required 0", ferr_cyc - fc0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL glitch_valid: got %0b required 0", rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int hs0;
        logic [7:0] e, g;
        logic [7:0] b;
        rx_ready = 1'b0;
        @(negedge clk);
        #3;
        send_frame(8'hAB, 1'b1);
        repeat (5) @(negedge clk);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_pre_valid: got %0b required 1", rx_valid); end
        total++; if (rx_data !== 8'hAB) begin bad++; $display("[TB] FAIL rstmid_pre_data: got %0h required ab", rx_data); end
        b = 8'hF0;
        @(negedge clk);
        #3;
        ser_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            ser_rx = b[i];
            #(BIT_NS);
        end
        ser_rx = b[4];
        #(BIT_NS / 2);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        total++; if (rx_data !== 8'h00) begin bad++; $display("[TB] FAIL rstmid_data: got %0h required 00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid: got %0b required 0", rx_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ferr: got %0b required 0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_overrun: got %0b required 0", overrun); end
        #(BIT_NS / 2);
        for (int i = 5; i < 8; i++) begin
            ser_rx = b[i];
            #(BIT_NS);
        end
        ser_rx = 1'b1;
        #(BIT_NS);
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        hs0 = hs_cnt;
        rx_ready = 1'b1;
        exp_q.push_back(8'h0F);
        @(negedge clk);
        #3;
        send_frame(8'h0F, 1'b1);
        repeat (20) @(negedge clk);
        total++; if (hs_cnt - hs0 !== 1) begin bad++; $display("[TB] FAIL rstmid_after_hs: got %0d required 1", hs_cnt - hs0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL rstmid_after_data: got nothing required %0h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin bad++; $display("[TB] FAIL rstmid_after_data: got %0h required %0h", g, e); end
            end
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        int hs0;
        logic [7:0] e, g;
        logic [7:0] b;
        hs0 = hs_cnt;
        b = 8'h80;
        rx_ready = 1'b1;
        exp_q.push_back(8'h80);
        @(negedge clk);
        #3;
        ser_rx = 1'b0;
        #(BIT_NS);
        ser_rx = b[0];
        #(BIT_NS / 2);
        ser_rx = ~b[0];
        #(CLK_NS);
        ser_rx = b[0];
        #(BIT_NS - BIT_NS / 2 - CLK_NS);
        for (int i = 1; i < 8; i++) begin
            ser_rx = b[i];
            #(BIT_NS);
        end
        ser_rx = 1'b1;
        #(BIT_NS);
        repeat (20) @(negedge clk);
        total++; if (hs_cnt - hs0 !== 1) begin bad++; $display("[TB] FAIL maj_handshakes: got %0d required 1", hs_cnt - hs0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_q.size() == 0) begin bad++; $display("[TB] FAIL maj_data: got nothing required %0h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin bad++; $display("[TB] FAIL maj_data: got %0h required %0h", g, e); end
            end
        end
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        hs_cnt    = 0;
        ferr_cyc  = 0;
        ferr_rise = 0;
        resetn    = 1'b0;
        ser_rx    = 1'b1;
        rx_ready  = 1'b0;
        $display("[TB] starting uart_rx bench, CLKS_PER_BIT=%0d", CPB);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_false_start();
        test_reset_mid_frame();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
